// File: rtl/traffic_pkg.sv
// Shared encodings for the highway/farm-road traffic-light controller.
package traffic_pkg;

  typedef logic [1:0] light_t;

  localparam light_t GREEN  = 2'b00;
  localparam light_t YELLOW = 2'b01;
  localparam light_t RED    = 2'b10;

  typedef enum logic [1:0] {
    HG = 2'd0,
    HY = 2'd1,
    FG = 2'd2,
    FY = 2'd3
  } state_t;

endpackage

// File: rtl/traffic_sync.sv
// N-flop synchronizer for asynchronous sensor/button inputs.
// Asynchronous active-low reset clears every stage to 0.
module traffic_sync #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[N-2:0], d};
  end

  assign q = ff[N-1];

endmodule

// File: rtl/traffic_ctrl.sv
// Four-phase highway/farm-road controller driving a shared interval timer.
// Optional pedestrian request/walk lamp enabled by defining TRAFFIC_PED_EN.
module traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       car,
  input  logic       tl,
  input  logic       ts,
  output logic       sc,
  output logic [1:0] hl,
  output logic [1:0] fl,
  output logic [1:0] state
`ifdef TRAFFIC_PED_EN
  ,
  input  logic       ped,
  output logic       walk
`endif
);

  state_t cur, nxt;
  logic   car_s, car_req, min_done;
  logic   hg_req, fg_early, enter_fg, enter_fy;

  traffic_sync #(.N(SYNC_STAGES)) u_car_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (car),
    .q     (car_s)
  );

`ifdef TRAFFIC_PED_EN
  logic ped_s, ped_req;

  traffic_sync #(.N(SYNC_STAGES)) u_ped_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ped),
    .q     (ped_s)
  );

  assign hg_req   = car_req | ped_req;
  // An active walk phase holds the farm road green until the long timer expires.
  assign fg_early = ~walk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_req <= 1'b0;
      walk    <= 1'b0;
    end else begin
      if (enter_fy)   ped_req <= 1'b0;
      else if (ped_s) ped_req <= 1'b1;
      if (enter_fg)      walk <= ped_req;
      else if (enter_fy) walk <= 1'b0;
    end
  end
`else
  assign hg_req   = car_req;
  assign fg_early = 1'b1;
`endif

  always_comb begin
    nxt = cur;
    sc  = 1'b0;
    hl  = RED;
    fl  = RED;
    unique case (cur)
      HG: begin
        hl = GREEN;
        if (tl && hg_req) begin
          sc  = 1'b1;
          nxt = HY;
        end
      end
      HY: begin
        hl = YELLOW;
        if (ts) begin
          sc  = 1'b1;
          nxt = FG;
        end
      end
      FG: begin
        fl = GREEN;
        if (tl || (fg_early && min_done && !car_s)) begin
          sc  = 1'b1;
          nxt = FY;
        end
      end
      FY: begin
        fl = YELLOW;
        if (ts) begin
          sc  = 1'b1;
          nxt = HG;
        end
      end
      default: begin
        nxt = HG;
      end
    endcase
  end

  assign enter_fg = (cur == HY) && sc;
  assign enter_fy = (cur == FG) && sc;
  assign state    = cur;

  // Clearing on FG entry takes priority over a new sensor request in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= HG;
      car_req  <= 1'b0;
      min_done <= 1'b0;
    end else begin
      cur <= nxt;
      if (enter_fg)                  car_req <= 1'b0;
      else if (car_s && cur != FG)   car_req <= 1'b1;
      if (enter_fg)                  min_done <= 1'b0;
      else if (cur == FG && ts)      min_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_traffic_ctrl.sv
// Self-checking bench for traffic_ctrl with a behavioural interval timer and
// a phase/elapsed-time reference model.
module tb_traffic_ctrl;

  localparam int unsigned N = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       car = 1'b0;
  logic       tl, ts, sc;
  logic [1:0] hl, fl, state;
`ifdef TRAFFIC_PED_EN
  logic       ped = 1'b0;
  logic       walk;
`endif

  int ran = 0;
  int fails = 0;

  always #5 clk = ~clk;

  traffic_ctrl #(.SYNC_STAGES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .car   (car),
    .tl    (tl),
    .ts    (ts),
    .sc    (sc),
    .hl    (hl),
    .fl    (fl),
    .state (state)
`ifdef TRAFFIC_PED_EN
    ,
    .ped   (ped),
    .walk  (walk)
`endif
  );

  // Paired interval timer: restarts on sc, saturates at 29, held in reset with the controller.
  int cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt <= 0;
    else if (sc)        cnt <= 0;
    else if (cnt < 29)  cnt <= cnt + 1;
  end
  assign tl = (cnt == 29);
  assign ts = (cnt == 2);

  // Reference model: phase index 0..3 (HG,HY,FG,FY), cycles spent in the phase, pending requests.
  int m_ph, m_el;
  bit m_req, m_preq, m_walk, m_g;
  bit m_hist[4];
`ifdef TRAFFIC_PED_EN
  bit m_phist[4];
`endif

  function automatic bit m_go();
    bit cs;
    cs = m_hist[N-1];
    case (m_ph)
      0:       return (m_el >= 29) && (m_req || m_preq);
      1, 3:    return m_el == 2;
      default: return (m_el >= 29) || (!m_walk && m_el >= 3 && !cs);
    endcase
  endfunction

  function automatic logic [6:0] m_exp();
    logic [1:0] eh, ef;
    eh = (m_ph == 0) ? 2'd0 : (m_ph == 1) ? 2'd1 : 2'd2;
    ef = (m_ph == 2) ? 2'd0 : (m_ph == 3) ? 2'd1 : 2'd2;
    return {2'(m_ph), eh, ef, m_go()};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0; m_el = 0; m_req = 0; m_preq = 0; m_walk = 0;
      for (int i = 0; i < 4; i++) m_hist[i] = 0;
`ifdef TRAFFIC_PED_EN
      for (int i = 0; i < 4; i++) m_phist[i] = 0;
`endif
    end else begin
      m_g = m_go();
      if (m_ph != 2 && m_hist[N-1]) m_req = 1;
      if (m_g && m_ph == 1) begin m_req = 0; m_walk = m_preq; end
`ifdef TRAFFIC_PED_EN
      if (m_phist[N-1]) m_preq = 1;
      if (m_g && m_ph == 2) begin m_preq = 0; m_walk = 0; end
      for (int i = N-1; i > 0; i--) m_phist[i] = m_phist[i-1];
      m_phist[0] = ped;
`endif
      if (m_g) begin m_ph = (m_ph + 1) % 4; m_el = 0; end
      else if (m_el < 29) m_el = m_el + 1;
      for (int i = N-1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = car;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int scs;
    rst_n = 1'b0; car = 1'b0;
    repeat (3) @(negedge clk);
    ran++;
    if ({state, hl, fl, sc} !== 7'b00_00_10_0) begin
      fails++;
      $display("FAIL reset_state got st=%0d hl=%0d fl=%0d sc=%0d exp st=0 hl=0 fl=2 sc=0", state, hl, fl, sc);
    end
    rst_n = 1'b1;
    scs = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      ran++;
      if ({state, hl, fl, sc} !== m_exp()) begin
        fails++;
        $display("FAIL idle_hg cyc=%0d got %b exp %b", i, {state, hl, fl, sc}, m_exp());
      end
      if (sc) scs++;
    end
    ran++;
    if (scs !== 0) begin
      fails++;
      $display("FAIL idle_no_sc got %0d sc pulses exp 0", scs);
    end
  endtask

  task automatic test_car_cycle();
    int first, hy, fg, fy;
    bit done;
    do_reset();
    first = -1; hy = 0; fg = 0; fy = 0; done = 0;
    for (int i = 1; i <= 200 && !done; i++) begin
      @(negedge clk);
      ran++;
      if ({state, hl, fl, sc} !== m_exp()) begin
        fails++;
        $display("FAIL car_cycle cyc=%0d got %b exp %b", i, {state, hl, fl, sc}, m_exp());
      end
      if (sc && first < 0) first = i;
      case (state)
        2'd1: hy++;
        2'd2: fg++;
        2'd3: fy++;
        default: if (fy > 0) done = 1;
      endcase
      if (i == 5) car = 1'b1;
    end
    ran++;
    if (!done) begin fails++; $display("FAIL car_cycle_timeout got no return to HG exp return"); end
    ran++;
    if (first !== 29) begin fails++; $display("FAIL hg_exit_count got %0d exp 29", first); end
    ran++;
    if (hy !== 3) begin fails++; $display("FAIL hy_len got %0d exp 3", hy); end
    ran++;
    if (fg !== 30) begin fails++; $display("FAIL fg_max_len got %0d exp 30", fg); end
    ran++;
    if (fy !== 3) begin fails++; $display("FAIL fy_len got %0d exp 3", fy); end
  endtask

  task automatic test_min_green();
    int fg;
    bit seen, left;
    car = 1'b1; fg = 0; seen = 0; left = 0;
    for (int i = 1; i <= 150 && !left; i++) begin
      @(negedge clk);
      ran++;
      if ({state, hl, fl, sc} !== m_exp()) begin
        fails++;
        $display("FAIL min_green cyc=%0d got %b exp %b", i, {state, hl, fl, sc}, m_exp());
      end
      if (state == 2'd2) begin
        if (!seen) car = 1'b0;
        seen = 1; fg++;
      end else if (seen) left = 1;
    end
    ran++;
    if (fg !== 4) begin fails++; $display("FAIL fg_min_len got %0d exp 4", fg); end
  endtask

  task automatic test_short_pulse();
    int first;
    do_reset();
    car = 1'b0; first = -1;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      ran++;
      if ({state, hl, fl, sc} !== m_exp()) begin
        fails++;
        $display("FAIL short_pulse cyc=%0d got %b exp %b", i, {state, hl, fl, sc}, m_exp());
      end
      if (sc && first < 0) first = i;
      if (i == 5) car = 1'b1;
      if (i == 5 + N + 1) car = 1'b0;
    end
    ran++;
    if (first !== 29) begin fails++; $display("FAIL pulse_latched got first sc at %0d exp 29", first); end
  endtask

  task automatic test_reset_mid_fy();
    int scs;
    bit hit;
    car = 1'b1; hit = 0;
    for (int i = 1; i <= 200 && !hit; i++) begin
      @(negedge clk);
      ran++;
      if ({state, hl, fl, sc} !== m_exp()) begin
        fails++;
        $display("FAIL to_fy cyc=%0d got %b exp %b", i, {state, hl, fl, sc}, m_exp());
      end
      if (state == 2'd3) hit = 1;
    end
    ran++;
    if (!hit) begin fails++; $display("FAIL fy_timeout got no FY exp FY"); end
    #2 rst_n = 1'b0;
    car = 1'b0;
    #1;
    ran++;
    if ({state, hl, fl, sc} !== 7'b00_00_10_0) begin
      fails++;
      $display("FAIL async_reset got st=%0d hl=%0d fl=%0d sc=%0d exp st=0 hl=0 fl=2 sc=0", state, hl, fl, sc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    scs = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      ran++;
      if ({state, hl, fl, sc} !== m_exp()) begin
        fails++;
        $display("FAIL post_reset cyc=%0d got %b exp %b", i, {state, hl, fl, sc}, m_exp());
      end
      if (sc) scs++;
    end
    ran++;
    if (scs !== 0) begin fails++; $display("FAIL post_reset_no_sc got %0d exp 0", scs); end
  endtask

  task automatic test_random();
    int phases;
    do_reset();
    phases = 0;
    for (int i = 1; i <= 1500; i++) begin
      @(negedge clk);
      ran++;
      if ({state, hl, fl, sc} !== m_exp()) begin
        fails++;
        $display("FAIL random cyc=%0d got %b exp %b", i, {state, hl, fl, sc}, m_exp());
      end
`ifdef TRAFFIC_PED_EN
      ran++;
      if (walk !== m_walk) begin fails++; $display("FAIL random_walk cyc=%0d got %0d exp %0d", i, walk, m_walk); end
      ped = ($urandom_range(0, 99) < 3);
`endif
      if (sc) phases++;
      if ($urandom_range(0, 24) == 0) car = ~car;
    end
    ran++;
    if (phases < 8) begin fails++; $display("FAIL random_activity got %0d phase changes exp >=8", phases); end
    car = 1'b0;
  endtask

`ifdef TRAFFIC_PED_EN
  task automatic test_ped();
    int fg, walkfg, first;
    bit fy_walk;
    do_reset();
    car = 1'b0; fg = 0; walkfg = 0; first = -1; fy_walk = 0;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      ran++;
      if ({state, hl, fl, sc, walk} !== {m_exp(), m_walk}) begin
        fails++;
        $display("FAIL ped cyc=%0d got %b exp %b", i, {state, hl, fl, sc, walk}, {m_exp(), m_walk});
      end
      if (sc && first < 0) first = i;
      if (state == 2'd2) begin fg++; if (walk) walkfg++; end
      if (state == 2'd3 && walk) fy_walk = 1;
      ped = (i >= 3 && i < 3 + N + 1);
    end
    ran++;
    if (first !== 29) begin fails++; $display("FAIL ped_hg_exit got %0d exp 29", first); end
    ran++;
    if (fg !== 30 || walkfg !== 30) begin
      fails++;
      $display("FAIL ped_walk_fg got fg=%0d walk=%0d exp 30/30", fg, walkfg);
    end
    ran++;
    if (fy_walk !== 1'b0) begin fails++; $display("FAIL ped_walk_fy got 1 exp 0"); end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_car_cycle();
    test_min_green();
    test_short_pulse();
    test_reset_mid_fy();
`ifdef TRAFFIC_PED_EN
    test_ped();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", ran, fails);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl.md
# traffic_ctrl

Four-phase highway/farm-road traffic-light controller that sequences the shared interval timer in the traffic_light design. It watches the farm-road car sensor and the timer's long (tl) and short (ts) expiry flags, issues the timer restart pulse (sc) on every phase change, and drives both roads' light encodings. It sits between the sensor pads and the lamp drivers, one instance per intersection, paired with exactly one timer.

## Interface

Parameters:
- SYNC_STAGES, 2, depth of the car/ped input synchronizer (legal values 2..3)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset; the paired timer must be held in reset by the same signal (inverted at top level for its active-high rst)
- car  input  1  farm-road vehicle sensor, asynchronous level
- tl  input  1  timer long expiry (count == 29, saturating)
- ts  input  1  timer short expiry (count == 2, one-cycle)
- sc  output  1  timer restart, combinational; high in the cycle before every state change
- hl  output  2  highway light: 2'b00 green, 2'b01 yellow, 2'b10 red
- fl  output  2  farm light, same encoding
- state  output  2  current phase, for debug/status
- ped  input  1  pedestrian button, asynchronous (TRAFFIC_PED_EN only)
- walk  output  1  walk lamp (TRAFFIC_PED_EN only)

## Operation

- States: HG (hl green, fl red), HY (hl yellow, fl red), FG (hl red, fl green), FY (hl red, fl yellow). Encoding HG=0, HY=1, FG=2, FY=3.
- car passes through a SYNC_STAGES flop synchronizer -> car_s.
- car_req: set when car_s=1 in any state other than FG; cleared on the edge entering FG (clear wins over set).
- min_done: cleared on the edge entering FG; set when ts=1 while in FG.
- Transitions (condition evaluated in the current cycle; sc = condition):
  - HG -> HY: tl && car_req
  - HY -> FG: ts
  - FG -> FY: tl || (min_done && !car_s)
  - FY -> HG: ts
- No other transitions; sc is 0 in every cycle where no transition fires.
- hl, fl, state are Moore outputs decoded from registered state; they are glitch-free.
- Reset (rst_n low, any time, including mid-phase): state=HG, hl=00, fl=10, car_req=0, min_done=0, synchronizer flops cleared, walk=0. sc=0 whenever the timer is in reset (tl=ts=0).

## Timing

- Phase change occurs on the edge following the cycle in which sc=1; the timer clears on that same edge (entry cycle count = 0).
- HY and FY: exactly 3 cycles (count 0,1,2; sc at count 2).
- HG: at least 30 cycles; exits on the first cycle with tl && car_req.
- FG: minimum 4 cycles (ts at count 2, min_done visible at count 3, exit edge after); maximum 30 cycles (tl at count 29).
- car to car_s latency: SYNC_STAGES cycles.
- Simultaneous tl and !car_s in FG: single transition to FY, one sc pulse.

## Configuration

- Macro TRAFFIC_PED_EN.
- Defined: ped/walk ports exist; ped synchronized like car; ped_req latched (set any state, cleared on entering FY). HG exit condition becomes tl && (car_req || ped_req). walk=1 throughout FG when ped_req was 1 on FG entry; while walk=1, FG exits only on tl (early !car_s exit suppressed). walk resets to 0.
- Undefined: ports absent, behaviour exactly as in Operation.

## Structure

- Package traffic_pkg: light encodings (GREEN, YELLOW, RED), state encodings (HG, HY, FG, FY), the 2-bit light type.
- One sub-module: traffic_sync (parameterized N-flop synchronizer, async active-low reset to 0), instantiated for car and, when enabled, ped.

## Test plan

- Reset release with car=0 held 100 cycles -> state stays HG, hl=00, fl=10, sc never asserted.
- car=1 from cycle 5 -> sc at timer count 29, HY for 3 cycles, FG entered; car held -> FG lasts 30 cycles, then FY 3 cycles, HG.
- Enter FG with car dropping to 0 at FG entry -> FG lasts exactly 4 cycles, then FY.
- car pulse of SYNC_STAGES+1 cycles during HG count 5 -> request latched, HG still exits at count 29.
- rst_n asserted mid-FY -> outputs HG/green/red immediately (asynchronously), car_req=0, no sc after release until new request.
- TRAFFIC_PED_EN: ped pulse, car=0 -> HG exits at tl, FG with walk=1 for 30 cycles despite car_s=0, walk=0 in FY.
